// File: rtl/sine_dds_pkg.sv
// Shared constants and table-generation helpers for the sine DDS.
package sine_dds_pkg;

  localparam logic [1:0] Q0 = 2'd0;
  localparam logic [1:0] Q1 = 2'd1;
  localparam logic [1:0] Q2 = 2'd2;
  localparam logic [1:0] Q3 = 2'd3;

  localparam int unsigned PIPE_LATENCY = 3;

  // pi/2 in Q2.30 fixed point
  localparam longint PI_HALF_Q30 = 64'sd1686629713;

  function automatic int unsigned amplitude(input int unsigned data_w);
    return (32'd1 << (data_w - 32'd1)) - 32'd1;
  endfunction

  // round(amplitude * sin(pi/2*(i+0.5)/2^addr_w)) via a Q30 Taylor series
  function automatic int unsigned quarter_sine(input int unsigned i,
                                               input int unsigned addr_w,
                                               input int unsigned data_w);
    longint x;
    longint x2;
    longint term;
    longint sum;
    x    = (PI_HALF_Q30 * longint'(2 * i + 1)) >>> (addr_w + 1);
    x2   = (x * x) >>> 30;
    term = x;
    sum  = x;
    for (int k = 1; k <= 10; k++) begin
      term = -((term * x2) >>> 30) / longint'((2 * k) * (2 * k + 1));
      sum  = sum + term;
    end
    return 32'((longint'(amplitude(data_w)) * sum + (64'sd1 <<< 29)) >>> 30);
  endfunction

endpackage

// File: rtl/sine_lut_quarter.sv
// Quarter-wave sine magnitude ROM with a registered read port.
module sine_lut_quarter
  import sine_dds_pkg::*;
#(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DATA_W = 12
) (
  input  logic              clk,
  input  logic              en,
  input  logic [ADDR_W-1:0] addr,
  output logic [DATA_W-2:0] data
);

  localparam int unsigned DEPTH = 32'd1 << ADDR_W;
  localparam int unsigned MAG_W = DATA_W - 1;

  logic [MAG_W-1:0] rom [DEPTH];

  for (genvar i = 0; i < DEPTH; i++) begin : g_rom
    assign rom[i] = MAG_W'(quarter_sine(i, ADDR_W, DATA_W));
  end

  // Output is only consumed when the accompanying valid bit is set, so no reset
  always_ff @(posedge clk) begin
    if (en) data <= rom[addr];
  end

endmodule

// File: rtl/sine_dds.sv
// Tick-enabled phase accumulator feeding a mirrored quarter-wave table;
// produces signed full-period sine samples three edges after each step.
module sine_dds
  import sine_dds_pkg::*;
#(
  parameter int unsigned PHASE_W = 24,
  parameter int unsigned ADDR_W  = 8,
  parameter int unsigned DATA_W  = 12
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     en,
  input  logic [PHASE_W-1:0]       ftw,
  input  logic                     ftw_load,
  input  logic [PHASE_W-1:0]       phase_off,
  input  logic                     clear,
  output logic signed [DATA_W-1:0] sample,
  output logic                     sample_valid,
  output logic                     phase_wrap
);

  localparam int unsigned MAG_W = DATA_W - 1;
  localparam int unsigned TOP_W = ADDR_W + 2;
  localparam int unsigned SHIFT = PHASE_W - TOP_W;

  if (PHASE_W < ADDR_W + 2) begin : g_bad_param
    $error("sine_dds: PHASE_W must be at least ADDR_W+2");
  end

  logic [PHASE_W-1:0] acc;
  logic [PHASE_W-1:0] ftw_reg;
  logic               step_v;
  logic               s1_v;
  logic               s2_v;
  logic [ADDR_W-1:0]  s1_idx;
  logic               s1_neg;
  logic               s2_neg;
  logic [MAG_W-1:0]   s2_mag;

  logic [TOP_W-1:0]   top_c;
  logic [1:0]         quad_c;
  logic [ADDR_W-1:0]  idx_c;
  logic [DATA_W-1:0]  mag_ext_c;

  // Truncated phase: quadrant in the top two bits, table index below
  always_comb begin
    top_c     = TOP_W'((acc + phase_off) >> SHIFT);
    quad_c    = top_c[TOP_W-1 -: 2];
    idx_c     = top_c[ADDR_W-1:0];
    mag_ext_c = {1'b0, s2_mag};
    if (quad_c == Q1 || quad_c == Q3) idx_c = ~idx_c;
  end

  // Tuning register and accumulator; clear wins over en
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc        <= '0;
      ftw_reg    <= '0;
      phase_wrap <= 1'b0;
      step_v     <= 1'b0;
    end else begin
      if (ftw_load) ftw_reg <= ftw;
      if (clear) begin
        acc        <= '0;
        phase_wrap <= 1'b0;
        step_v     <= 1'b0;
      end else if (en) begin
        {phase_wrap, acc} <= {1'b0, acc} + {1'b0, ftw_reg};
        step_v            <= 1'b1;
      end else begin
        phase_wrap <= 1'b0;
        step_v     <= 1'b0;
      end
    end
  end

  // Mirror/sign pipeline; data always advances, valid bits are flushed by clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_v         <= 1'b0;
      s1_idx       <= '0;
      s1_neg       <= 1'b0;
      s2_v         <= 1'b0;
      s2_neg       <= 1'b0;
      sample_valid <= 1'b0;
      sample       <= '0;
    end else begin
      s1_v         <= step_v & ~clear;
      s1_idx       <= idx_c;
      s1_neg       <= (quad_c == Q2) || (quad_c == Q3);
      s2_v         <= s1_v & ~clear;
      s2_neg       <= s1_neg;
      sample_valid <= s2_v & ~clear;
      if (s2_v && !clear) sample <= s2_neg ? -mag_ext_c : mag_ext_c;
    end
  end

  sine_lut_quarter #(
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W)
  ) u_lut (
    .clk (clk),
    .en  (s1_v),
    .addr(s1_idx),
    .data(s2_mag)
  );

endmodule

// File: tb/tb_sine_dds.sv
// Self-checking bench for sine_dds (PHASE_W=8, ADDR_W=4, DATA_W=8).
module tb_sine_dds;
  import sine_dds_pkg::*;

  localparam int unsigned PW = 8;
  localparam int unsigned AW = 4;
  localparam int unsigned DW = 8;
  localparam int BIN = 1 << (PW - AW - 2);
  localparam real PI = 3.14159265358979323846;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic en = 1'b0;
  logic ftw_load = 1'b0;
  logic clear = 1'b0;
  logic [PW-1:0] ftw = '0;
  logic [PW-1:0] phase_off = '0;
  logic signed [DW-1:0] sample;
  logic sample_valid;
  logic phase_wrap;

  int checks = 0;
  int errors = 0;

  sine_dds #(.PHASE_W(PW), .ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .ftw(ftw), .ftw_load(ftw_load),
    .phase_off(phase_off), .clear(clear), .sample(sample),
    .sample_valid(sample_valid), .phase_wrap(phase_wrap)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  // Reference: sample = round(A * sin(2*pi*phase_centre/2^PW)), symmetric rounding
  function automatic int ref_sine(input int phase);
    real y;
    int pt;
    pt = phase - (phase % BIN);
    y  = real'(amplitude(DW)) * $sin(2.0 * PI * (real'(pt) + real'(BIN) / 2.0) / real'(1 << PW));
    if (y >= 0.0) return int'($floor(y + 0.5));
    return -int'($floor(-y + 0.5));
  endfunction

  typedef struct { int due; int val; } exp_t;
  exp_t pend_q[$];
  int  m_acc, m_ftw, m_sample, cyc;
  bit  m_pend;

  task automatic check(input string name, input logic signed [31:0] act,
                       input logic signed [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle=%0d actual=%0d expected=%0d", name, cyc, act, exp);
    end
  endtask

  task automatic model_reset();
    pend_q.delete();
    m_acc = 0; m_ftw = 0; m_sample = 0; m_pend = 0;
  endtask

  // One clock edge: advance the model with the inputs seen at the edge, then compare
  task automatic tick();
    bit exp_v;
    int exp_wrap;
    int sum;
    @(posedge clk);
    #1;
    cyc++;
    exp_v = 0;
    exp_wrap = 0;
    if (!rst_n) begin
      model_reset();
    end else begin
      if (clear) begin
        pend_q.delete();
        m_pend = 0;
        m_acc  = 0;
      end else begin
        if (m_pend) pend_q.push_back('{cyc + 2, ref_sine((m_acc + int'(phase_off)) % (1 << PW))});
        m_pend = en;
        if (en) begin
          sum      = m_acc + m_ftw;
          exp_wrap = (sum >> PW) & 1;
          m_acc    = sum % (1 << PW);
        end
        if (pend_q.size() > 0 && pend_q[0].due == cyc) begin
          exp_v    = 1;
          m_sample = pend_q[0].val;
          void'(pend_q.pop_front());
        end
      end
      if (ftw_load) m_ftw = int'(ftw);
    end
    check("model_valid", sample_valid, exp_v);
    check("model_sample", sample, m_sample);
    check("model_wrap", phase_wrap, exp_wrap);
  endtask

  typedef struct { logic [PW-1:0] poff; int exp; } vec_t;
  vec_t vecs[5];
  int got[4];
  int per[128];
  int nsamp, nstrobe, nneg;
  logic [7:0] vbits;
  logic [3:0] wbits;

  initial begin
    vecs = '{'{8'h00, 6}, '{8'h40, 127}, '{8'h80, -6}, '{8'hC0, -127}, '{8'h7C, 6}};
    cyc = 0;
    model_reset();

    // Reset state
    tick(); tick();
    check("rst_sample", sample, 0);
    check("rst_valid", sample_valid, 0);
    check("rst_wrap", phase_wrap, 0);
    rst_n = 1'b1;

    // Quadrant mapping
    foreach (vecs[i]) begin
      clear = 1; ftw_load = 1; ftw = '0; phase_off = vecs[i].poff; tick();
      clear = 0; ftw_load = 0; en = 1; tick();
      en = 0;
      repeat (PIPE_LATENCY) tick();
      check("quad_valid", sample_valid, 1);
      check("quad_sample", sample, vecs[i].exp);
    end

    // Latency of a single step and hold afterwards
    phase_off = '0;
    clear = 1; ftw_load = 1; ftw = 8'h10; tick();
    clear = 0; ftw_load = 0; en = 1; tick();
    en = 0;
    vbits[0] = sample_valid;
    for (int i = 1; i < 8; i++) begin
      tick();
      vbits[i] = sample_valid;
      if (i >= 3) check("lat_sample", sample, 54);
    end
    check("lat_strobe", vbits, 8'b0000_1000);

    // Wrap strobe with ftw=0x80
    clear = 1; ftw_load = 1; ftw = 8'h80; tick();
    clear = 0; ftw_load = 0; nsamp = 0; wbits = '0;
    for (int i = 0; i < 8; i++) begin
      en = (i < 4);
      tick();
      if (i < 4) wbits[i] = phase_wrap;
      if (sample_valid) begin
        if (nsamp < 4) got[nsamp] = int'(sample);
        nsamp++;
      end
    end
    en = 0;
    check("wrap_bits", wbits, 4'b1010);
    check("wrap_count", nsamp, 4);
    for (int i = 0; i < 4; i++) check("wrap_sample", got[i], (i % 2 == 0) ? -6 : 6);

    // ftw_load together with en uses the old tuning word
    clear = 1; ftw_load = 1; ftw = 8'h04; tick();
    clear = 0; ftw = 8'h10; en = 1; tick();
    ftw_load = 0; tick();
    en = 0; nsamp = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (sample_valid) begin
        if (nsamp < 2) got[nsamp] = int'(sample);
        nsamp++;
      end
    end
    check("ftw_count", nsamp, 2);
    check("ftw_first", got[0], 19);
    check("ftw_second", got[1], 65);

    // Full period with ftw=0x04
    clear = 1; ftw_load = 1; ftw = 8'h04; tick();
    clear = 0; ftw_load = 0; en = 1; nsamp = 0; nneg = 0;
    for (int i = 0; i < 140 && nsamp < 128; i++) begin
      tick();
      if (sample_valid) begin
        per[nsamp] = int'(sample);
        if (sample == -8'sd128) nneg++;
        nsamp++;
      end
    end
    en = 0;
    check("period_count", nsamp, 128);
    check("period_no_min", nneg, 0);
    check("period_peak", per[15], 127);
    check("period_trough", per[47], -127);
    for (int j = 0; j < 32; j++) check("period_odd", per[j + 32], -per[j]);
    for (int j = 0; j < 64; j++) check("period_repeat", per[j + 64], per[j]);

    // Asynchronous reset during continuous stepping
    ftw_load = 1; ftw = 8'h04; en = 1; tick();
    ftw_load = 0;
    repeat (6) tick();
    #3 rst_n = 0;
    #1;
    check("arst_sample", sample, 0);
    check("arst_valid", sample_valid, 0);
    model_reset();
    tick();
    rst_n = 1; en = 0; nstrobe = 0;
    repeat (6) begin tick(); nstrobe += int'(sample_valid); end
    check("arst_nostrobe", nstrobe, 0);
    ftw_load = 1; ftw = 8'h40; tick();
    ftw_load = 0; clear = 1; en = 1; tick();
    clear = 0; en = 0; nstrobe = 0;
    repeat (5) begin tick(); nstrobe += int'(sample_valid); end
    check("clr_nostrobe", nstrobe, 0);
    en = 1; tick();
    en = 0;
    repeat (PIPE_LATENCY) tick();
    check("clr_prio_valid", sample_valid, 1);
    check("clr_prio_sample", sample, 127);

    // Randomised traffic against the model
    repeat (400) begin
      en        = ($urandom_range(0, 9) < 7);
      clear     = ($urandom_range(0, 29) == 0);
      ftw_load  = ($urandom_range(0, 9) == 0);
      ftw       = 8'($urandom);
      phase_off = 8'($urandom);
      tick();
    end
    en = 0; clear = 0; ftw_load = 0;
    repeat (5) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
